// File: rtl/rx_phy_pkg.sv
// Shared definitions for the 8-bit PHY receive path.
//   COM          : K28.5 comma symbol that starts every ordered set
//   lock_state_t : symbol-lock FSM encoding (UNLOCK=0, ACQ=1, LOCKED=2)
//   idx_width()  : bit width of a symbol index within an ordered set
package rx_phy_pkg;

    localparam logic [7:0] COM = 8'hBC;

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    // Ordered sets are at least two symbols long, so one bit is the floor.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rx_sym_stage.sv
// Enable-gated output register for the consumed symbol.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_enb      : symbol strobe; outputs load only when high, otherwise hold
//   i_data     : raw byte being consumed
//   i_valid    : lane will be LOCKED after this symbol
//   i_idx      : position of this symbol within its ordered set
//   o_data     : registered byte
//   o_k285     : registered "byte is COM" flag
//   o_valid    : registered lane-valid flag
//   o_idx      : registered symbol index
module rx_sym_stage
    import rx_phy_pkg::*;
#(
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enb,
    input  logic [7:0]       i_data,
    input  logic             i_valid,
    input  logic [IDX_W-1:0] i_idx,
    output logic [7:0]       o_data,
    output logic             o_k285,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    logic [7:0]       r_data;
    logic             r_k285;
    logic             r_valid;
    logic [IDX_W-1:0] r_idx;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order the blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_k285  <= 1'b0;
            r_valid <= 1'b0;
            r_idx   <= '0;
        end else if (i_enb) begin
            r_data  <= i_data;
            r_k285  <= (i_data == COM);
            r_valid <= i_valid;
            r_idx   <= i_idx;
        end
    end

    assign o_data  = r_data;
    assign o_k285  = r_k285;
    assign o_valid = r_valid;
    assign o_idx   = r_idx;

endmodule

// File: rtl/rx_sync_ctrl.sv
// Receive-side symbol-lock controller. Acquires ordered-set alignment from
// LOCK_CNT correctly spaced COMs and drops it after ERR_MAX consecutive
// alignment errors. All outputs are registered, one symbol of latency.
//   clk        : clock
//   rst        : asynchronous active-low reset
//   enb        : symbol strobe; one symbol consumed per cycle when high
//   rx_DataE   : incoming byte
//   rx_DataS   : registered consumed byte
//   k285       : consumed byte was COM
//   rx_Valid   : lane is LOCKED after the consumed byte
//   sym_idx    : index of the consumed byte within its ordered set
//   lock_state : FSM state after the consumed byte
//   err_pulse  : one-cycle pulse per alignment error while LOCKED
module rx_sync_ctrl
    import rx_phy_pkg::*;
#(
    parameter int OS_LEN   = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERR_MAX  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enb,
    input  logic [7:0]                   rx_DataE,
    output logic [7:0]                   rx_DataS,
    output logic                         k285,
    output logic                         rx_Valid,
    output logic [idx_width(OS_LEN)-1:0] sym_idx,
    output logic [1:0]                   lock_state,
    output logic                         err_pulse
);

    localparam int POS_W = idx_width(OS_LEN);
    localparam int GC_W  = $clog2(LOCK_CNT) + 1;
    localparam int EC_W  = $clog2(ERR_MAX) + 1;

    lock_state_t      r_state, w_nxt_state;
    logic [POS_W-1:0] r_pos, w_nxt_pos, w_pos_inc, w_sym_idx;
    logic [GC_W-1:0]  r_good_cnt, w_nxt_good, w_good_inc;
    logic [EC_W-1:0]  r_err_cnt, w_nxt_err, w_err_inc;
    logic             r_err_pulse, w_err;
    logic             w_is_com, w_at_com_slot;

    assign w_is_com      = (rx_DataE == COM);
    assign w_at_com_slot = (r_pos == '0);
    assign w_pos_inc     = (r_pos == POS_W'(OS_LEN - 1)) ? '0 : r_pos + POS_W'(1);
    assign w_good_inc    = r_good_cnt + GC_W'(1);
    assign w_err_inc     = r_err_cnt + EC_W'(1);

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_pos   = w_pos_inc;
        w_nxt_good  = r_good_cnt;
        w_nxt_err   = r_err_cnt;
        w_err       = 1'b0;
        w_sym_idx   = r_pos;

        unique case (r_state)
            UNLOCK: begin
                if (w_is_com) begin
                    // With LOCK_CNT == 1 the first COM is already enough to lock.
                    w_nxt_state = (LOCK_CNT == 1) ? LOCKED : ACQ;
                    w_nxt_good  = GC_W'(1);
                    w_nxt_err   = '0;
                    w_nxt_pos   = POS_W'(1);
                end else begin
                    w_nxt_pos = '0;
                end
            end
            ACQ: begin
                if (w_at_com_slot && w_is_com) begin
                    w_nxt_good = w_good_inc;
                    if (w_good_inc == GC_W'(LOCK_CNT)) begin
                        w_nxt_state = LOCKED;
                        w_nxt_err   = '0;
                    end
                end else if (w_at_com_slot) begin
                    w_nxt_state = UNLOCK;
                    w_nxt_good  = '0;
                    w_nxt_err   = '0;
                    w_nxt_pos   = '0;
                end else if (w_is_com) begin
                    // Misplaced COM: restart acquisition around this symbol,
                    // which is reported as index 0 of a new ordered set.
                    w_nxt_good = GC_W'(1);
                    w_nxt_pos  = POS_W'(1);
                    w_sym_idx  = '0;
                end
            end
            LOCKED: begin
                if (w_at_com_slot && w_is_com) begin
                    w_nxt_err = '0;
                end else if (w_at_com_slot || w_is_com) begin
                    // Missing or misplaced COM; a misplaced COM never realigns.
                    w_err     = 1'b1;
                    w_nxt_err = w_err_inc;
                    if (w_err_inc == EC_W'(ERR_MAX)) begin
                        w_nxt_state = UNLOCK;
                        w_nxt_good  = '0;
                        w_nxt_err   = '0;
                        w_nxt_pos   = '0;
                    end
                end
            end
            default: begin
                w_nxt_state = UNLOCK;
                w_nxt_good  = '0;
                w_nxt_err   = '0;
                w_nxt_pos   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= UNLOCK;
            r_pos       <= '0;
            r_good_cnt  <= '0;
            r_err_cnt   <= '0;
            r_err_pulse <= 1'b0;
        end else if (enb) begin
            r_state     <= w_nxt_state;
            r_pos       <= w_nxt_pos;
            r_good_cnt  <= w_nxt_good;
            r_err_cnt   <= w_nxt_err;
            r_err_pulse <= w_err;
        end else begin
            // Everything holds across an enable gap except the error pulse.
            r_err_pulse <= 1'b0;
        end
    end

    rx_sym_stage #(
        .IDX_W (POS_W)
    ) u_sym_stage (
        .clk     (clk),
        .rst_n   (rst),
        .i_enb   (enb),
        .i_data  (rx_DataE),
        .i_valid (w_nxt_state == LOCKED),
        .i_idx   (w_sym_idx),
        .o_data  (rx_DataS),
        .o_k285  (k285),
        .o_valid (rx_Valid),
        .o_idx   (sym_idx)
    );

    // The state register already holds the state after the last consumed symbol.
    assign lock_state = r_state;
    assign err_pulse  = r_err_pulse;

endmodule
